multicycle_control: RTL and testbench

- Main sequencing FSM for the multicycle MIPS datapath.
- Steps each instruction through fetch, decode, execute, memory and writeback states, one state per clock.
- Drives the enable/mux strobes and the 2-bit alu_op consumed by the ALU control decoder.
- Stalls on a memory-ready handshake and traps illegal opcodes.

---
 rtl/mips_pkg.sv | 50 +++++
 rtl/multicycle_control.sv | 158 +++++++++++++++
 tb/tb_multicycle_control.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path: opcode/funct
// constants, the sequencing FSM states and the datapath mux encodings
// that the ALU control decoder also relies on.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_JR     = 6'b001000;

  // One state per clock of instruction execution; codes 14 and 15 are unused
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11,
    S_JREX    = 4'd12,
    S_TRAP    = 4'd13
  } state_t;

  // ALU operation request handed to the ALU control decoder
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // Second ALU operand select
  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // Next-PC source select
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_REGA   = 2'b11;

endpackage

// File: rtl/multicycle_control.sv
// Main sequencing FSM of the multicycle MIPS datapath. Walks each
// instruction through fetch/decode/execute/memory/writeback, stalls on the
// memory-ready handshake and parks in a trap state on unknown opcodes.
module multicycle_control
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       branch,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       illegal,
  output logic       instr_done
);

  state_t state;
  state_t next_state;

  // State register plus sticky illegal flag; only reset leaves the trap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_FETCH;
      illegal <= 1'b0;
    end else begin
      state <= next_state;
      if (next_state == S_TRAP)
        illegal <= 1'b1;
    end
  end

  // Next-state selection from the current state, opcode, funct and mem_ready
  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH:   next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE:     next_state = S_RTYPEEX;
          OP_BEQ:       next_state = S_BEQEX;
          OP_ADDI:      next_state = S_ADDIEX;
          OP_J:         next_state = S_JEX;
          default:      next_state = S_TRAP;
        endcase
      end
      S_MEMADR:  next_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   next_state = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:   next_state = S_FETCH;
      S_MEMWR:   next_state = mem_ready ? S_FETCH : S_MEMWR;
      S_RTYPEEX: next_state = (funct == F_JR) ? S_JREX : S_RTYPEWB;
      S_RTYPEWB: next_state = S_FETCH;
      S_BEQEX:   next_state = S_FETCH;
      S_ADDIEX:  next_state = S_ADDIWB;
      S_ADDIWB:  next_state = S_FETCH;
      S_JEX:     next_state = S_FETCH;
      S_JREX:    next_state = S_FETCH;
      S_TRAP:    next_state = S_TRAP;
      default:   next_state = S_FETCH;
    endcase
  end

  // Strobe decode from state; fetch commits are held off while reset is asserted
  always_comb begin
    pc_write   = 1'b0;
    branch     = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    alu_op     = ALU_ADD;
    pc_src     = PC_ALU;
    instr_done = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready & ~reset;
        pc_write  = mem_ready & ~reset;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMMSH;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        mem_write  = 1'b1;
        instr_done = mem_ready;
      end
      S_RTYPEEX: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      S_RTYPEWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      S_BEQEX: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_SUB;
        branch     = 1'b1;
        pc_src     = PC_ALUOUT;
        instr_done = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_ADDIWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_JEX: begin
        pc_write   = 1'b1;
        pc_src     = PC_JUMP;
        instr_done = 1'b1;
      end
      S_JREX: begin
        pc_write   = 1'b1;
        pc_src     = PC_REGA;
        instr_done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control. A behavioural model expands
// each instruction into its list of execution steps and the strobes each
// step must show, then replays it against the mem_ready pattern driven.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       mem_ready;
  logic       pc_write, branch, iord, mem_read, mem_write, ir_write;
  logic       reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic       illegal, instr_done;

  multicycle_control dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .funct      (funct),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .branch     (branch),
    .iord       (iord),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_src     (pc_src),
    .illegal    (illegal),
    .instr_done (instr_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       instr_done;
  } outs_t;

  typedef enum {P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR,
                P_REX, P_RWB, P_BEQ, P_AEX, P_AWB, P_J, P_JR, P_TRAP} phase_t;

  int     n_checks = 0;
  int     n_fails  = 0;
  outs_t  obs_q[$];
  logic   ill_q[$];
  outs_t  exp_q[$];
  phase_t plan[$];
  bit     mr_pat[$];

  function automatic outs_t sample_outs();
    outs_t o;
    o = {pc_write, branch, iord, mem_read, mem_write, ir_write, reg_write,
         reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, instr_done};
    return o;
  endfunction

  // Strobes that each execution step must present
  function automatic outs_t model_out(phase_t ph, logic mr);
    outs_t o;
    o = '0;
    case (ph)
      P_FETCH:  begin o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = mr; o.pc_write = mr; end
      P_DECODE: begin o.alu_src_b = 2'b11; end
      P_MEMADR: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      P_MEMRD:  begin o.iord = 1; o.mem_read = 1; end
      P_MEMWB:  begin o.reg_write = 1; o.mem_to_reg = 1; o.instr_done = 1; end
      P_MEMWR:  begin o.iord = 1; o.mem_write = 1; o.instr_done = mr; end
      P_REX:    begin o.alu_src_a = 1; o.alu_op = 2'b10; end
      P_RWB:    begin o.reg_write = 1; o.reg_dst = 1; o.instr_done = 1; end
      P_BEQ:    begin o.alu_src_a = 1; o.alu_op = 2'b01; o.branch = 1; o.pc_src = 2'b01; o.instr_done = 1; end
      P_AEX:    begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      P_AWB:    begin o.reg_write = 1; o.instr_done = 1; end
      P_J:      begin o.pc_write = 1; o.pc_src = 2'b10; o.instr_done = 1; end
      P_JR:     begin o.pc_write = 1; o.pc_src = 2'b11; o.instr_done = 1; end
      default:  o = '0;
    endcase
    return o;
  endfunction

  function automatic bit pat_at(int i);
    return (i < mr_pat.size()) ? mr_pat[i] : 1'b1;
  endfunction

  // Expand an instruction into the ordered list of steps it goes through
  function automatic void plan_instr(logic [5:0] op, logic [5:0] fn);
    plan.delete();
    plan.push_back(P_FETCH);
    plan.push_back(P_DECODE);
    case (op)
      6'b100011: begin plan.push_back(P_MEMADR); plan.push_back(P_MEMRD); plan.push_back(P_MEMWB); end
      6'b101011: begin plan.push_back(P_MEMADR); plan.push_back(P_MEMWR); end
      6'b000000: begin plan.push_back(P_REX); plan.push_back((fn == 6'b001000) ? P_JR : P_RWB); end
      6'b000100: plan.push_back(P_BEQ);
      6'b001000: begin plan.push_back(P_AEX); plan.push_back(P_AWB); end
      6'b000010: plan.push_back(P_J);
      default:   plan.push_back(P_TRAP);
    endcase
  endfunction

  // Replay the step list against the mem_ready pattern: memory steps repeat while not ready
  function automatic void build_exp(logic [5:0] op, logic [5:0] fn, int max_cycles);
    int     k;
    phase_t ph;
    outs_t  o;
    bit     mr;
    exp_q.delete();
    plan_instr(op, fn);
    k = 0;
    for (int i = 0; i < max_cycles; i++) begin
      ph = plan[k];
      mr = pat_at(i);
      o  = model_out(ph, mr);
      exp_q.push_back(o);
      if (o.instr_done) break;
      if (ph != P_TRAP && (mr || !(ph inside {P_FETCH, P_MEMRD, P_MEMWR})))
        k++;
    end
  endfunction

  // Drive one instruction from FETCH until instr_done or the cycle budget runs out
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int max_cycles);
    outs_t o;
    opcode = op;
    funct  = fn;
    obs_q.delete();
    ill_q.delete();
    for (int i = 0; i < max_cycles; i++) begin
      mem_ready = pat_at(i);
      @(negedge clk);
      o = sample_outs();
      obs_q.push_back(o);
      ill_q.push_back(illegal);
      @(posedge clk);
      #1;
      if (o.instr_done) break;
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    outs_t rv;
    rv = '0;
    rv.mem_read  = 1'b1;
    rv.alu_src_b = 2'b01;
    reset     = 1'b1;
    mem_ready = 1'b1;
    opcode    = 6'b100011;
    funct     = 6'b000000;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks++;
      if (sample_outs() !== rv) begin
        n_fails++;
        $display("[TB] FAIL reset_outputs: got %h expected %h", sample_outs(), rv);
      end
      n_checks++;
      if (illegal !== 1'b0) begin
        n_fails++;
        $display("[TB] FAIL reset_illegal: got %b expected 0", illegal);
      end
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_lw();
    int dones;
    mr_pat.delete();
    run_instr(6'b100011, 6'($urandom), 20);
    build_exp(6'b100011, 6'b0, 20);
    n_checks++;
    if (obs_q.size() !== 5) begin
      n_fails++;
      $display("[TB] FAIL lw_latency: got %0d cycles expected 5", obs_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fails++;
        $display("[TB] FAIL lw_cycle%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    if (obs_q.size() > 4) begin
      n_checks++;
      if ({obs_q[4].reg_write, obs_q[4].mem_to_reg} !== 2'b11) begin
        n_fails++;
        $display("[TB] FAIL lw_writeback: got %b%b expected 11", obs_q[4].reg_write, obs_q[4].mem_to_reg);
      end
    end
    dones = 0;
    foreach (obs_q[i]) dones += int'(obs_q[i].instr_done);
    n_checks++;
    if (dones !== 1) begin
      n_fails++;
      $display("[TB] FAIL lw_done_pulses: got %0d expected 1", dones);
    end
  endtask

  task automatic test_sw();
    int writes;
    mr_pat = '{1, 1, 1, 0, 0, 0, 1};
    run_instr(6'b101011, 6'($urandom), 20);
    build_exp(6'b101011, 6'b0, 20);
    n_checks++;
    if (obs_q.size() !== 7) begin
      n_fails++;
      $display("[TB] FAIL sw_latency: got %0d cycles expected 7", obs_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fails++;
        $display("[TB] FAIL sw_cycle%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    writes = 0;
    foreach (obs_q[i]) writes += int'(obs_q[i].mem_write);
    n_checks++;
    if (writes !== 4) begin
      n_fails++;
      $display("[TB] FAIL sw_write_cycles: got %0d expected 4", writes);
    end
  endtask

  task automatic test_rtype();
    mr_pat.delete();
    run_instr(6'b000000, 6'b100000, 20);
    build_exp(6'b000000, 6'b100000, 20);
    n_checks++;
    if (obs_q.size() !== 4) begin
      n_fails++;
      $display("[TB] FAIL add_latency: got %0d cycles expected 4", obs_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fails++;
        $display("[TB] FAIL add_cycle%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    if (obs_q.size() > 3) begin
      n_checks++;
      if (obs_q[2].alu_op !== 2'b10 || obs_q[3].reg_dst !== 1'b1) begin
        n_fails++;
        $display("[TB] FAIL add_aluop_regdst: got %b/%b expected 10/1", obs_q[2].alu_op, obs_q[3].reg_dst);
      end
    end
  endtask

  task automatic test_jr();
    int writes;
    mr_pat.delete();
    run_instr(6'b000000, 6'b001000, 20);
    build_exp(6'b000000, 6'b001000, 20);
    n_checks++;
    if (obs_q.size() !== 4) begin
      n_fails++;
      $display("[TB] FAIL jr_latency: got %0d cycles expected 4", obs_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fails++;
        $display("[TB] FAIL jr_cycle%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    if (obs_q.size() > 3) begin
      n_checks++;
      if (obs_q[3].pc_src !== 2'b11 || obs_q[3].pc_write !== 1'b1) begin
        n_fails++;
        $display("[TB] FAIL jr_pc: got pc_src %b pc_write %b expected 11/1", obs_q[3].pc_src, obs_q[3].pc_write);
      end
    end
    writes = 0;
    foreach (obs_q[i]) writes += int'(obs_q[i].reg_write);
    n_checks++;
    if (writes !== 0) begin
      n_fails++;
      $display("[TB] FAIL jr_no_regwrite: got %0d writes expected 0", writes);
    end
  endtask

  task automatic test_beq_j();
    mr_pat.delete();
    run_instr(6'b000100, 6'($urandom), 20);
    n_checks++;
    if (obs_q.size() !== 3) begin
      n_fails++;
      $display("[TB] FAIL beq_latency: got %0d cycles expected 3", obs_q.size());
    end else begin
      n_checks++;
      if (obs_q[2].alu_op !== 2'b01 || obs_q[2].branch !== 1'b1) begin
        n_fails++;
        $display("[TB] FAIL beq_exec: got alu_op %b branch %b expected 01/1", obs_q[2].alu_op, obs_q[2].branch);
      end
    end
    run_instr(6'b000010, 6'($urandom), 20);
    n_checks++;
    if (obs_q.size() !== 3) begin
      n_fails++;
      $display("[TB] FAIL j_latency: got %0d cycles expected 3", obs_q.size());
    end else begin
      n_checks++;
      if (obs_q[2].pc_src !== 2'b10 || obs_q[2].pc_write !== 1'b1) begin
        n_fails++;
        $display("[TB] FAIL j_exec: got pc_src %b pc_write %b expected 10/1", obs_q[2].pc_src, obs_q[2].pc_write);
      end
    end
  endtask

  task automatic test_random();
    logic [5:0] ops [6];
    logic [5:0] op, fn;
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    for (int n = 0; n < 40; n++) begin
      op = ops[$urandom_range(5)];
      fn = ($urandom_range(3) == 0) ? 6'b001000 : 6'($urandom);
      mr_pat.delete();
      for (int j = 0; j < 10; j++) mr_pat.push_back($urandom_range(3) != 0);
      run_instr(op, fn, 30);
      build_exp(op, fn, 30);
      n_checks++;
      if (obs_q.size() !== exp_q.size()) begin
        n_fails++;
        $display("[TB] FAIL rand%0d_latency op %b: got %0d cycles expected %0d", n, op, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fails++;
          $display("[TB] FAIL rand%0d_cycle%0d op %b funct %b: got %h expected %h", n, i, op, fn, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_trap();
    mr_pat.delete();
    run_instr(6'b111111, 6'($urandom), 12);
    build_exp(6'b111111, 6'b0, 12);
    n_checks++;
    if (obs_q.size() !== 12) begin
      n_fails++;
      $display("[TB] FAIL trap_cycles: got %0d expected 12", obs_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fails++;
        $display("[TB] FAIL trap_cycle%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
      n_checks++;
      if (ill_q[i] !== (i >= 2)) begin
        n_fails++;
        $display("[TB] FAIL trap_illegal%0d: got %b expected %b", i, ill_q[i], (i >= 2));
      end
    end
  endtask

  task automatic test_reset_midinstr();
    outs_t rv;
    rv = '0;
    rv.mem_read  = 1'b1;
    rv.alu_src_b = 2'b01;
    mem_ready = 1'b0;
    apply_reset();
    @(negedge clk);
    n_checks++;
    if (illegal !== 1'b0) begin
      n_fails++;
      $display("[TB] FAIL trap_cleared: got %b expected 0", illegal);
    end
    @(posedge clk);
    #1;
    opcode    = 6'b100011;
    funct     = 6'b000000;
    mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    mem_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (sample_outs() !== model_out(P_MEMRD, 1'b0)) begin
      n_fails++;
      $display("[TB] FAIL midreset_in_memrd: got %h expected %h", sample_outs(), model_out(P_MEMRD, 1'b0));
    end
    #1;
    reset = 1'b1;
    #1;
    n_checks++;
    if (sample_outs() !== rv || illegal !== 1'b0) begin
      n_fails++;
      $display("[TB] FAIL midreset_async: got %h/%b expected %h/0", sample_outs(), illegal, rv);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (sample_outs() !== model_out(P_FETCH, 1'b0) || illegal !== 1'b0) begin
      n_fails++;
      $display("[TB] FAIL midreset_fetch: got %h/%b expected %h/0", sample_outs(), illegal, model_out(P_FETCH, 1'b0));
    end
  endtask

  initial begin
    reset     = 1'b1;
    mem_ready = 1'b0;
    opcode    = 6'b0;
    funct     = 6'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_lw();
    test_sw();
    test_rtype();
    test_jr();
    test_beq_j();
    test_random();
    test_trap();
    test_reset_midinstr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
